// File: rtl/myproject_mul_pkg.sv
// myproject_mul_pkg: shared sizing rules and the saturate/wrap narrowing helper
// used by the myproject_mul_pipe multiplier.
package myproject_mul_pkg;

  // Widest intermediate value handled by the narrowing helper.
  localparam int MAX_W = 64;

  localparam logic signed [MAX_W-1:0] WIDE_ONE  = 64'sd1;
  localparam logic signed [MAX_W-1:0] WIDE_SMAX = {1'b0, {(MAX_W-1){1'b1}}};
  localparam logic signed [MAX_W-1:0] WIDE_SMIN = {1'b1, {(MAX_W-1){1'b0}}};

  // Narrowed value (low bits meaningful) plus a flag saying the value was altered.
  typedef struct packed {
    logic [MAX_W-1:0] value;
    logic             ovf;
  } narrow_t;

  // Full product width: one spare bit so mixed-signedness products stay exact.
  function automatic int calc_prod_w(input int w0, input int w1);
    return w0 + w1 + 1;
  endfunction

  function automatic logic signed [MAX_W-1:0] signed_max(input int width);
    if (width >= MAX_W) return WIDE_SMAX;
    return (WIDE_ONE <<< (width - 1)) - WIDE_ONE;
  endfunction

  function automatic logic signed [MAX_W-1:0] signed_min(input int width);
    if (width >= MAX_W) return WIDE_SMIN;
    return -(WIDE_ONE <<< (width - 1));
  endfunction

  function automatic logic signed [MAX_W-1:0] unsigned_max(input int width);
    if (width >= MAX_W - 1) return WIDE_SMAX;
    return (WIDE_ONE <<< width) - WIDE_ONE;
  endfunction

  // Narrow a wide signed value to 'width' bits, clamping or dropping MSBs.
  // The range is signed when is_signed is set, otherwise 0..2^width-1.
  function automatic narrow_t sat_narrow(input logic signed [MAX_W-1:0] value,
                                         input int                      width,
                                         input logic                    is_signed,
                                         input logic                    sat);
    narrow_t                 r;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    logic signed [MAX_W-1:0] mask;
    hi    = is_signed ? signed_max(width) : unsigned_max(width);
    lo    = is_signed ? signed_min(width) : '0;
    mask  = unsigned_max(width);
    r.ovf = (value > hi) || (value < lo);
    if (sat && (value > hi)) begin
      r.value = hi;
    end else if (sat && (value < lo)) begin
      r.value = lo;
    end else begin
      r.value = value & mask;
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_mul_pipe_ctrl.sv
// myproject_mul_pipe_ctrl: stage-valid shift register and pipeline-advance
// (ce) generation. The whole pipeline moves together or freezes together.
module myproject_mul_pipe_ctrl
  import myproject_mul_pkg::*;
#(
  parameter int NUM_STAGE = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din_valid,
  input  logic i_dout_ready,
  output logic o_din_ready,
  output logic o_ce,
  output logic o_dout_valid,
  output logic o_last_load
);

  logic [NUM_STAGE-1:0] r_valid;
  logic                 w_ce;
  logic                 w_last_in;

  assign w_ce         = ~r_valid[NUM_STAGE-1] | i_dout_ready;
  assign o_ce         = w_ce;
  assign o_din_ready  = w_ce;
  assign o_dout_valid = r_valid[NUM_STAGE-1];
  assign o_last_load  = w_ce & w_last_in;

  generate
    if (NUM_STAGE == 1) begin : g_single
      assign w_last_in = i_din_valid;
    end else begin : g_multi
      assign w_last_in = r_valid[NUM_STAGE-2];
    end
  endgenerate

  // Valid bits march one stage per advancing cycle; bubbles travel as zeros.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= '0;
    end else if (w_ce) begin
      r_valid[0] <= i_din_valid;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_valid[i] <= r_valid[i-1];
      end
    end
  end

endmodule

// File: rtl/myproject_mul_pipe.sv
// myproject_mul_pipe: pipelined multiplier with valid/ready stall, arithmetic
// output shift and saturate/wrap narrowing.
// Optional accumulate mode is enabled with the macro MYPROJECT_MUL_ACC_EN.
module myproject_mul_pipe
  import myproject_mul_pkg::*;
#(
  parameter int DIN0_W      = 13,
  parameter int DIN1_W      = 11,
  parameter int DIN0_SIGNED = 0,
  parameter int DIN1_SIGNED = 0,
  parameter int DOUT_W      = 24,
  parameter int SHIFT       = 0,
  parameter int SAT         = 0,
  parameter int NUM_STAGE   = 2
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
`ifdef MYPROJECT_MUL_ACC_EN
  input  logic              din_first,
`endif
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DOUT_W-1:0] dout,
  output logic              ovf
);

  localparam int   PROD_W     = calc_prod_w(DIN0_W, DIN1_W);
  localparam logic RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);
  localparam logic SAT_EN     = (SAT != 0);

  logic                     w_ce;
  logic                     w_last_load;
  logic [DIN0_W-1:0]        w_a;
  logic [DIN1_W-1:0]        w_b;
  logic signed [PROD_W-1:0] w_mul;
  logic signed [PROD_W-1:0] w_prod_last;
  logic signed [PROD_W-1:0] w_shifted;
  logic signed [MAX_W-1:0]  w_wide;
  narrow_t                  w_nr;
  logic [DOUT_W-1:0]        w_dout_next;
  logic                     w_ovf_next;
  logic [DOUT_W-1:0]        r_dout;
  logic                     r_ovf;
  logic                     w_unused_hi;
`ifdef MYPROJECT_MUL_ACC_EN
  logic                     w_first_last;
  narrow_t                  w_acc;
`endif

  myproject_mul_pipe_ctrl #(
    .NUM_STAGE(NUM_STAGE)
  ) u_ctrl (
    .i_clk       (ap_clk),
    .i_rst_n     (ap_rst_n),
    .i_din_valid (din_valid),
    .i_dout_ready(dout_ready),
    .o_din_ready (din_ready),
    .o_ce        (w_ce),
    .o_dout_valid(dout_valid),
    .o_last_load (w_last_load)
  );

  function automatic logic signed [PROD_W-1:0] ext0(input logic [DIN0_W-1:0] v);
    logic s;
    s = (DIN0_SIGNED != 0) ? v[DIN0_W-1] : 1'b0;
    return {{(PROD_W-DIN0_W){s}}, v};
  endfunction

  function automatic logic signed [PROD_W-1:0] ext1(input logic [DIN1_W-1:0] v);
    logic s;
    s = (DIN1_SIGNED != 0) ? v[DIN1_W-1] : 1'b0;
    return {{(PROD_W-DIN1_W){s}}, v};
  endfunction

  // Reinterpret a narrowed result in the output number range (signed or not).
  function automatic logic signed [MAX_W-1:0] ext_res(input logic [DOUT_W-1:0] v);
    logic s;
    s = RES_SIGNED ? v[DOUT_W-1] : 1'b0;
    return {{(MAX_W-DOUT_W){s}}, v};
  endfunction

  generate
    if (NUM_STAGE == 1) begin : g_comb_in
      assign w_a = din0;
      assign w_b = din1;
`ifdef MYPROJECT_MUL_ACC_EN
      assign w_first_last = din_first;
`endif
    end else begin : g_reg_in
      logic [DIN0_W-1:0] r_a;
      logic [DIN1_W-1:0] r_b;

      // Stage 1 captures the operand pair whenever the pipeline advances.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ce) begin
          r_a <= din0;
          r_b <= din1;
        end
      end

      assign w_a = r_a;
      assign w_b = r_b;

`ifdef MYPROJECT_MUL_ACC_EN
      logic [NUM_STAGE-2:0] r_first;

      // The first-beat marker travels alongside its operands to the last stage.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_first <= '0;
        end else if (w_ce) begin
          r_first[0] <= din_first;
          for (int i = 1; i < NUM_STAGE - 1; i++) begin
            r_first[i] <= r_first[i-1];
          end
        end
      end

      assign w_first_last = r_first[NUM_STAGE-2];
`endif
    end
  endgenerate

  assign w_mul = ext0(w_a) * ext1(w_b);

  generate
    if (NUM_STAGE <= 2) begin : g_no_mid
      assign w_prod_last = w_mul;
    end else begin : g_mid
      logic signed [PROD_W-1:0] r_prod [NUM_STAGE-2];

      // Middle stages carry the exact product toward the narrowing stage.
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          for (int i = 0; i < NUM_STAGE - 2; i++) begin
            r_prod[i] <= '0;
          end
        end else if (w_ce) begin
          r_prod[0] <= w_mul;
          for (int i = 1; i < NUM_STAGE - 2; i++) begin
            r_prod[i] <= r_prod[i-1];
          end
        end
      end

      assign w_prod_last = r_prod[NUM_STAGE-3];
    end
  endgenerate

  // Arithmetic shift on a signed value floors toward minus infinity.
  assign w_shifted = w_prod_last >>> SHIFT;
  assign w_wide    = {{(MAX_W-PROD_W){w_shifted[PROD_W-1]}}, w_shifted};
  assign w_nr      = sat_narrow(w_wide, DOUT_W, RES_SIGNED, SAT_EN);

`ifdef MYPROJECT_MUL_ACC_EN
  assign w_acc = sat_narrow(ext_res(r_dout) + ext_res(w_nr.value[DOUT_W-1:0]),
                            DOUT_W, RES_SIGNED, SAT_EN);

  // A first beat restarts the sum; later beats add onto the held result.
  always_comb begin
    w_dout_next = w_nr.value[DOUT_W-1:0];
    w_ovf_next  = w_nr.ovf;
    if (!w_first_last) begin
      w_dout_next = w_acc.value[DOUT_W-1:0];
      w_ovf_next  = w_nr.ovf | w_acc.ovf;
    end
  end

  assign w_unused_hi = ^{w_nr.value[MAX_W-1:DOUT_W], w_acc.value[MAX_W-1:DOUT_W]};
`else
  assign w_dout_next = w_nr.value[DOUT_W-1:0];
  assign w_ovf_next  = w_nr.ovf;
  assign w_unused_hi = ^w_nr.value[MAX_W-1:DOUT_W];
`endif

  // Output stage loads only for a valid slot, so dout holds over stalls and bubbles.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else if (w_last_load) begin
      r_dout <= w_dout_next;
      r_ovf  <= r_ovf | w_ovf_next;
    end
  end

  assign dout = r_dout;
  assign ovf  = r_ovf;

endmodule

// File: doc/myproject_mul_pipe.md
Name: myproject_mul_pipe

Overview:
- Parametrised, pipelined multiplier for the hls4ml layer datapaths; next generation of the fixed-width combinational mul primitives.
- Operand widths, signedness, pipeline depth and output scaling are configurable.
- Adds a valid/ready handshake with full-pipeline stall, an output right-shift, and a saturate/wrap mode.
- Sits between dense-layer weight/activation streams and the adder tree.

Parameters:
DIN0_W, 13, width of operand 0
DIN1_W, 11, width of operand 1
DIN0_SIGNED, 0, 1 = din0 is two's complement
DIN1_SIGNED, 0, 1 = din1 is two's complement
DOUT_W, 24, result width
SHIFT, 0, arithmetic right shift applied to the full product before narrowing (0..DIN0_W+DIN1_W-1)
SAT, 0, 1 = saturate on narrowing overflow; 0 = wrap (drop MSBs)
NUM_STAGE, 2, register stages from input accept to dout_valid (>=1)

Ports:
ap_clk  in  1  clock, rising edge
ap_rst_n  in  1  asynchronous active-low reset
din_valid  in  1  operand pair valid
din_ready  out  1  block can accept this cycle
din0  in  DIN0_W  operand 0
din1  in  DIN1_W  operand 1
dout_valid  out  1  result valid
dout_ready  in  1  downstream accepts
dout  out  DOUT_W  result
ovf  out  1  sticky overflow flag, set when saturation/wrap altered a result

Behaviour:
- Reset (async assert, sync deassert externally): every stage-valid bit is 0; dout_valid=0, dout=0, ovf=0; din_ready=1 after reset.
- Stall: ce = ~dout_valid | dout_ready. din_ready = ce (combinational). All stages shift only when ce=1; the whole pipeline freezes otherwise. There is no bubble collapsing.
- Accept: din_valid & din_ready. The stage-0 valid bit loads din_valid whenever ce=1, so bubbles propagate as invalid slots.
- Latency: a pair accepted in cycle t gives dout_valid in cycle t+NUM_STAGE, absent stalls. Throughput is 1 per cycle while dout_ready=1.
- dout and dout_valid hold stable while dout_valid & ~dout_ready (AXI-stream rule).
- Product rule:
  - Operands are extended per their signedness to PROD_W = DIN0_W+DIN1_W+1.
  - The full product is exact.
  - The shift is arithmetic right by SHIFT, truncating toward −inf.
- Narrowing to DOUT_W:
  - SAT=1: clamp to the DOUT_W min/max. The signed range applies if either operand is signed; otherwise 0..2^DOUT_W−1.
  - SAT=0: keep the low DOUT_W bits.
- ovf: set in the cycle the altered result is presented; cleared only by reset.
- Stage placement: stage 1 registers operands; the multiply sits in the middle stages; shift/narrow is registered in the last stage. If NUM_STAGE=1, the combinational multiply and narrow feed the single register.
- Reset mid-operation: all in-flight data is discarded and no dout_valid pulses after reset releases.
- Simultaneous din accept and dout consume in the same cycle: both occur, with no loss or duplication.

Optional Feature:
- Macro: MYPROJECT_MUL_ACC_EN.
- Defined:
  - Adds input port din_first (1 bit, qualified with din_valid) and an accumulator of DOUT_W bits in the last stage.
  - Each accepted beat presents acc = narrow(product) when din_first=1; otherwise it presents acc = sat/wrap(acc + narrow(product)), per SAT.
  - The accumulator updates only when a valid slot advances with ce=1.
  - The accumulator resets to 0.
  - ovf also covers accumulator overflow.
- Undefined: no din_first port and a pure multiply as above. Port list and latency are otherwise identical.

Decomposition:
- Package myproject_mul_pkg holds:
  - the PROD_W calculation function;
  - a sat_narrow function (value, width, signed, sat) returning result plus overflow;
  - localparams for signed min/max.
- One natural sub-module, myproject_mul_pipe_ctrl: the valid-bit shift register, ce and din_ready generation. The datapath stays in the top.

Test Plan:
- Defaults, 13'd8191 × 11'd2047 with dout_ready=1 → dout=24'd16767 k… exactly 16,766,977 two cycles later; ovf=0.
- DIN0_SIGNED=DIN1_SIGNED=1, DOUT_W=8, SAT=1: −100 × 3 → dout=−128, ovf=1. With SAT=0 → low byte 0xD4, ovf=1.
- SHIFT=4, signed: −17 × 1 → −2 (floor), not −1.
- Stream of 10 back-to-back pairs with dout_ready toggling 1,0,0,1…:
  - all 10 results come out in order, with no drops or duplicates;
  - dout is stable during stalls;
  - din_ready equals ce every cycle.
- Assert ap_rst_n low with 2 pairs in flight → dout_valid=0 immediately (async); no stale outputs after release.
- With MYPROJECT_MUL_ACC_EN: beats (3×4, first=1), (2×5), (1×1) → outputs 12, 22, 23. A new first=1 beat of 2×2 → 4.
